// File: rtl/pe_pkg.sv
// Shared PE datapath definitions: coefficient width, coefficient type, default modulus.
package pe_pkg;

  localparam int COEFF_W = 23;

  typedef logic [COEFF_W-1:0] coeff_t;

  localparam coeff_t Q_DEFAULT = 23'h6D3410;

endpackage

// File: rtl/mod_add_core.sv
// Combinational modular-add pieces: sum and trial subtract (pre stage 1), select (pre stage 2).
// Pure logic, no latency; the caller supplies the registered sum/difference for the select.
module mod_add_core
  import pe_pkg::*;
#(
  parameter int W = COEFF_W
) (
  input  logic [W-1:0]        a,
  input  logic [W-1:0]        b,
  input  logic [W-1:0]        q,
  output logic [W:0]          sum,
  output logic signed [W+1:0] diff,
  input  logic [W:0]          sum_r,
  input  logic signed [W+1:0] diff_r,
  output logic [W-1:0]        res
);

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = $signed({1'b0, sum}) - $signed({2'b00, q});

  // A negative trial difference means the sum was already below q.
  assign res = diff_r[W+1] ? sum_r[W-1:0] : diff_r[W-1:0];

  // Top bits only matter for unreduced operands, whose result is truncated anyway.
  logic unused_bits;
  assign unused_bits = ^{sum_r[W], diff_r[W]};

endmodule

// File: rtl/mod_add_pipe.sv
// Two-stage pipelined (a + b) mod q; result valid one edge after stage 1 captures the operands.
// Valid/ready both sides; in_ready_o is combinational from out_ready_i, full rate when not stalled.
module mod_add_pipe
  import pe_pkg::*;
#(
  parameter int W = COEFF_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] q_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] c_o
);

  logic                v1;
  logic                v2;
  logic [W:0]          s_q;
  logic signed [W+1:0] d_q;
  logic [W-1:0]        c_q;

  logic                ld1;
  logic                ld2;
  logic                in_xfer;
  logic [W:0]          sum;
  logic signed [W+1:0] diff;
  logic [W-1:0]        res;

  mod_add_core #(.W(W)) u_core (
    .a      (a_i),
    .b      (b_i),
    .q      (q_i),
    .sum    (sum),
    .diff   (diff),
    .sum_r  (s_q),
    .diff_r (d_q),
    .res    (res)
  );

  assign ld2        = !v2 || out_ready_i;
  assign ld1        = !v1 || ld2;
  assign in_ready_o = ld1;
  assign in_xfer    = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      s_q <= '0;
      d_q <= '0;
      c_q <= '0;
    end else begin
      if (ld1) begin
        v1 <= in_xfer;
        if (in_xfer) begin
          s_q <= sum;
          d_q <= diff;
        end
      end
      // c_o keeps its last value when stage 2 drains without new data.
      if (ld2) begin
        v2 <= v1;
        if (v1) begin
          c_q <= res;
        end
      end
    end
  end

  assign out_valid_o = v2;
  assign c_o         = c_q;

endmodule
